serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder, one full-adder cell reused for WIDTH cycles.
// Ports: clk, rst (sync, active-high), start, a/b/cin (sampled on acceptance) ->
//        busy (RUN), done (1-cycle pulse), sum/cout (held until next acceptance),
//        ovf (signed overflow, only when SERIAL_ADD_OVF_EN is defined).
// Build option: `define SERIAL_ADD_OVF_EN to add the ovf port and its logic.

module half_adder_delay (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             p, g0, s_bit, g1, c_bit;
  logic             run, accept, last;

  half_adder_delay u_ha0 (.x(a_q[0]), .y(b_q[0]),  .s(p),     .c(g0));
  half_adder_delay u_ha1 (.x(p),      .y(carry_q), .s(s_bit), .c(g1));
  assign c_bit = g0 | g1;

  // A new operation may be accepted from IDLE or directly from DONE (back-to-back).
  assign run    = state_q == RUN;
  assign accept = (state_q == IDLE || state_q == DONE) && start;
  assign last   = run && cnt_q == LAST;

  always_comb begin
    state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    a_d     = accept ? a : run ? a_q >> 1 : a_q;
    b_d     = accept ? b : run ? b_q >> 1 : b_q;
    carry_d = accept ? cin : run ? c_bit : carry_q;
    cnt_d   = (run && !last) ? cnt_q + CW'(1) : (accept || last) ? '0 : cnt_q;
    sum_d   = accept ? '0 : run ? {s_bit, sum_q[WIDTH-1:1]} : sum_q;
    cout_d  = accept ? 1'b0 : last ? c_bit : cout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // In the last RUN cycle carry_q is the carry into the MSB and c_bit the carry out of it.
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = accept ? 1'b0 : last ? carry_q ^ c_bit : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign busy = run;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
